// File: rtl/mir_pkg.sv
// Shared definitions for the EV22 microinstruction sequencer:
// field layout, opcodes, microinstruction constants and step table.
package mir_pkg;

   localparam int iALUC_HI = 33;
   localparam int iALUC_LO = 30;
   localparam int iKMX     = 29;
   localparam int iM_RD    = 28;
   localparam int iM_WR    = 27;
   localparam int iBUSA_HI = 26;
   localparam int iBUSA_LO = 24;
   localparam int iBUSB_HI = 23;
   localparam int iBUSB_LO = 21;
   localparam int iBUSC_HI = 20;
   localparam int iBUSC_LO = 18;
   localparam int iSH_HI   = 17;
   localparam int iSH_LO   = 16;
   localparam int iT_HI    = 15;
   localparam int iT_LO    = 0;

   localparam logic [3:0] NOP_i   = 4'h0;
   localparam logic [3:0] MOVwK_i = 4'h1;
   localparam logic [3:0] ADDwK_i = 4'h2;
   localparam logic [3:0] SUBwK_i = 4'h3;
   localparam logic [3:0] ANDwK_i = 4'h4;
   localparam logic [3:0] ORwK_i  = 4'h5;
   localparam logic [3:0] LD_i    = 4'h6;
   localparam logic [3:0] ST_i    = 4'h7;
   localparam logic [3:0] BR_i    = 4'h8;
   localparam logic [3:0] BSR_i   = 4'h9;
   localparam logic [3:0] RET_i   = 4'hA;

   // Extended opcodes live in the second nibble when the first is 0
   localparam logic [3:0] X_NOP_i   = 4'h0;
   localparam logic [3:0] X_MOVww_i = 4'h1;
   localparam logic [3:0] X_ADDww_i = 4'h2;
   localparam logic [3:0] X_SUBww_i = 4'h3;
   localparam logic [3:0] X_SHLw_i  = 4'h4;

   // {aluc, kmx, m_rd, m_wr, busA, busB, busC, sh, t}
   localparam logic [33:0] NOP_u    = '0;
   localparam logic [33:0] MOVwK_u  = {4'h0, 3'b100, 3'd0, 3'd0, 3'd1, 2'd0, 16'h0010};
   localparam logic [33:0] ADDwK_u  = {4'h1, 3'b100, 3'd0, 3'd0, 3'd1, 2'd0, 16'h0020};
   localparam logic [33:0] SUBwK_u  = {4'h2, 3'b100, 3'd0, 3'd0, 3'd1, 2'd0, 16'h0030};
   localparam logic [33:0] ANDwK_u  = {4'h3, 3'b100, 3'd0, 3'd0, 3'd1, 2'd0, 16'h0040};
   localparam logic [33:0] ORwK_u   = {4'h4, 3'b100, 3'd0, 3'd0, 3'd1, 2'd0, 16'h0050};
   localparam logic [33:0] LD_u     = {4'h0, 3'b010, 3'd0, 3'd2, 3'd1, 2'd0, 16'h0060};
   localparam logic [33:0] ST_u     = {4'h0, 3'b001, 3'd0, 3'd1, 3'd0, 2'd0, 16'h0070};
   localparam logic [33:0] BR_u     = {4'h0, 3'b100, 3'd0, 3'd0, 3'd4, 2'd0, 16'h0080};
   localparam logic [33:0] BSR_u    = {4'h1, 3'b001, 3'd0, 3'd4, 3'd0, 2'd0, 16'h0090};
   localparam logic [33:0] BSR2_u   = {4'h0, 3'b100, 3'd0, 3'd0, 3'd4, 2'd0, 16'h0091};
   localparam logic [33:0] RET_u    = {4'h0, 3'b010, 3'd0, 3'd2, 3'd5, 2'd0, 16'h00A0};
   localparam logic [33:0] RET2_u   = {4'h0, 3'b000, 3'd0, 3'd5, 3'd4, 2'd0, 16'h00A1};
   localparam logic [33:0] MOVww_u  = {4'h0, 3'b000, 3'd2, 3'd3, 3'd1, 2'd0, 16'h0101};
   localparam logic [33:0] ADDww_u  = {4'h1, 3'b000, 3'd2, 3'd3, 3'd1, 2'd0, 16'h0102};
   localparam logic [33:0] SUBww_u  = {4'h2, 3'b000, 3'd2, 3'd3, 3'd1, 2'd0, 16'h0103};
   localparam logic [33:0] SHLw_u   = {4'h0, 3'b000, 3'd2, 3'd0, 3'd1, 2'd2, 16'h0104};
   localparam logic [33:0] FIX_A_SH = {4'h0, 3'b000, 3'd1, 3'd0, 3'd0, 2'd1, 16'h0000};
   localparam logic [33:0] A_SH_MASK = {7'b0, 3'b111, 6'b0, 2'b11, 16'b0};

   typedef enum logic {EMPTY = 1'b0, ISSUE = 1'b1} state_t;

   function automatic int steps_of(input logic [3:0] op);
      case (op)
         BSR_i, RET_i: steps_of = 2;
         default:      steps_of = 1;
      endcase
   endfunction

endpackage

// File: rtl/mir_rom.sv
// Combinational decode of (instruction, step) into a microinstruction
// plus last/illegal flags.
module mir_rom
   import mir_pkg::*;
#(
   parameter int INST_W     = 20,
   parameter int UINST_W    = 34,
   parameter int MAX_STEPS  = 2,
   parameter int EXT_DECODE = 1,
   parameter int SW         = 1
) (
   input  logic [INST_W-1:0]  inst,
   input  logic [SW-1:0]      step,
   output logic [UINST_W-1:0] uinst,
   output logic               last,
   output logic               illegal
);

   logic [3:0]  op;
   logic [3:0]  xop;
   logic [33:0] raw;
   logic        fixed;
   logic        unused_lo;
   int          n;

   assign op        = inst[INST_W-1 -: 4];
   assign xop       = inst[INST_W-5 -: 4];
   assign unused_lo = ^inst[INST_W-9:0];

   always_comb begin
      raw     = NOP_u;
      fixed   = 1'b1;
      illegal = 1'b0;
      case (op)
         NOP_i: begin
            fixed = 1'b0;
            if (EXT_DECODE != 0) begin
               case (xop)
                  X_NOP_i:   raw = NOP_u;
                  X_MOVww_i: raw = MOVww_u;
                  X_ADDww_i: raw = ADDww_u;
                  X_SUBww_i: raw = SUBww_u;
                  X_SHLw_i:  raw = SHLw_u;
                  default:   illegal = 1'b1;
               endcase
            end
         end
         MOVwK_i: raw = MOVwK_u;
         ADDwK_i: raw = ADDwK_u;
         SUBwK_i: raw = SUBwK_u;
         ANDwK_i: raw = ANDwK_u;
         ORwK_i:  raw = ORwK_u;
         LD_i:    raw = LD_u;
         ST_i:    raw = ST_u;
         BR_i:    raw = BR_u;
         BSR_i:   raw = (step == '0) ? BSR_u : BSR2_u;
         RET_i:   raw = (step == '0) ? RET_u : RET2_u;
         default: begin
            fixed   = 1'b0;
            illegal = 1'b1;
         end
      endcase
      if (fixed)
         raw = (raw & ~A_SH_MASK) | (FIX_A_SH & A_SH_MASK);
      n = steps_of(op);
      // Truncate long sequences at the counter's ceiling
      last  = (int'(step) + 1 >= n) || (int'(step) >= MAX_STEPS - 1);
      uinst = UINST_W'(raw);
   end

endmodule

// File: rtl/mir_seq.sv
// Microinstruction sequencer stage: valid/ready in, one registered
// microinstruction per step out, with stall and flush.
module mir_seq
   import mir_pkg::*;
#(
   parameter int INST_W     = 20,
   parameter int UINST_W    = 34,
   parameter int MAX_STEPS  = 2,
   parameter int EXT_DECODE = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               inst_valid,
   output logic               inst_ready,
   input  logic [INST_W-1:0]  inst,
   input  logic               flush,
   output logic               uinst_valid,
   input  logic               uinst_ready,
   output logic [UINST_W-1:0] uinst,
   output logic               uinst_last,
   output logic               uinst_illegal
);

   localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

   state_t              state_q, state_d;
   logic [INST_W-1:0]   held_q, held_d;
   logic [SW-1:0]       step_q, step_d;
   logic [UINST_W-1:0]  uinst_q, uinst_d;
   logic                last_q, last_d;
   logic                ill_q, ill_d;

   logic [INST_W-1:0]   rom_inst;
   logic [SW-1:0]       rom_step;
   logic [UINST_W-1:0]  rom_uinst;
   logic                rom_last;
   logic                rom_ill;
   logic                accept;
   logic                advance;
   logic                retire;

   assign uinst_valid   = (state_q == ISSUE);
   assign uinst         = uinst_q;
   assign uinst_last    = last_q;
   assign uinst_illegal = ill_q;

   assign inst_ready = !flush && (!uinst_valid || (uinst_ready && last_q));
   assign accept     = inst_valid && inst_ready;
   assign advance    = uinst_valid && uinst_ready && !last_q;
   assign retire     = uinst_valid && uinst_ready && last_q;

   // One decoder serves both a fresh accept and the next held step
   assign rom_inst = accept ? inst : held_q;
   assign rom_step = accept ? '0 : step_q + SW'(1);

   mir_rom #(
      .INST_W     (INST_W),
      .UINST_W    (UINST_W),
      .MAX_STEPS  (MAX_STEPS),
      .EXT_DECODE (EXT_DECODE),
      .SW         (SW)
   ) u_rom (
      .inst    (rom_inst),
      .step    (rom_step),
      .uinst   (rom_uinst),
      .last    (rom_last),
      .illegal (rom_ill)
   );

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      step_d  = step_q;
      uinst_d = uinst_q;
      last_d  = last_q;
      ill_d   = ill_q;
      if (flush) begin
         state_d = EMPTY;
         step_d  = '0;
      end else if (accept) begin
         state_d = ISSUE;
         held_d  = inst;
         step_d  = '0;
         uinst_d = rom_uinst;
         last_d  = rom_last;
         ill_d   = rom_ill;
      end else if (advance) begin
         step_d  = rom_step;
         uinst_d = rom_uinst;
         last_d  = rom_last;
         ill_d   = rom_ill;
      end else if (retire) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         held_q  <= '0;
         step_q  <= '0;
         uinst_q <= UINST_W'(NOP_u);
         last_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         step_q  <= step_d;
         uinst_q <= uinst_d;
         last_q  <= last_d;
         ill_q   <= ill_d;
      end
   end

endmodule

// File: tb/tb_mir_seq.sv
// Bench for mir_seq: directed scenarios plus random traffic against a
// queue-style reference model, for both extended-decode settings.
module tb_mir_seq;
   import mir_pkg::*;

   typedef struct packed {
      logic [33:0] u;
      logic        last;
      logic        ill;
   } item_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        inst_valid = 1'b0;
   logic [19:0] inst = '0;
   logic        flush = 1'b0;
   logic        uinst_ready = 1'b0;

   logic        rdy1, val1, last1, ill1;
   logic        rdy0, val0, last0, ill0;
   logic [33:0] u1, u0;
   logic [36:0] o1, o0;

   int checks = 0;
   int errors = 0;

   bit    m_valid [2];
   item_t m_cur   [2];
   item_t m_nxt   [2];
   bit    m_has   [2];

   logic [33:0] t1 [16];
   bit          l1 [16];
   logic [33:0] tx [16];
   bit          lx [16];

   always #5 clk = ~clk;

   assign o1 = {val1, last1, ill1, u1};
   assign o0 = {val0, last0, ill0, u0};

   mir_seq #(.EXT_DECODE(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid),
      .inst_ready(rdy1), .inst(inst), .flush(flush),
      .uinst_valid(val1), .uinst_ready(uinst_ready), .uinst(u1),
      .uinst_last(last1), .uinst_illegal(ill1)
   );

   mir_seq #(.EXT_DECODE(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid),
      .inst_ready(rdy0), .inst(inst), .flush(flush),
      .uinst_valid(val0), .uinst_ready(uinst_ready), .uinst(u0),
      .uinst_last(last0), .uinst_illegal(ill0)
   );

   function automatic logic [33:0] fix(input logic [33:0] u);
      logic [33:0] f;
      logic [33:0] r;
      f = FIX_A_SH;
      r = u;
      r[iBUSA_HI:iBUSA_LO] = f[iBUSA_HI:iBUSA_LO];
      r[iSH_HI:iSH_LO]     = f[iSH_HI:iSH_LO];
      return r;
   endfunction

   task automatic init_tables();
      for (int i = 0; i < 16; i++) begin
         t1[i] = NOP_u; l1[i] = 1'b0;
         tx[i] = NOP_u; lx[i] = 1'b0;
      end
      t1[MOVwK_i] = MOVwK_u; t1[ADDwK_i] = ADDwK_u;
      t1[SUBwK_i] = SUBwK_u; t1[ANDwK_i] = ANDwK_u;
      t1[ORwK_i]  = ORwK_u;  t1[LD_i]    = LD_u;
      t1[ST_i]    = ST_u;    t1[BR_i]    = BR_u;
      t1[BSR_i]   = BSR_u;   t1[RET_i]   = RET_u;
      for (int i = 1; i <= 10; i++) l1[i] = 1'b1;
      tx[X_MOVww_i] = MOVww_u; tx[X_ADDww_i] = ADDww_u;
      tx[X_SUBww_i] = SUBww_u; tx[X_SHLw_i]  = SHLw_u;
      for (int i = 0; i <= 4; i++) lx[i] = 1'b1;
   endtask

   // Expected microinstruction list for one instruction
   task automatic expand(input logic [19:0] ins, input bit ext,
                         output item_t a, output item_t b, output int n);
      logic [3:0] op;
      logic [3:0] x;
      op = ins[19:16];
      x  = ins[15:12];
      n  = 1;
      a  = '{u: NOP_u, last: 1'b1, ill: 1'b0};
      b  = a;
      if (op == 4'h0) begin
         if (ext && lx[x])  a.u = tx[x];
         else if (ext)      a.ill = 1'b1;
      end else if (l1[op]) begin
         a.u = fix(t1[op]);
         if (op == BSR_i || op == RET_i) begin
            n = 2;
            a.last = 1'b0;
            b.u = fix(op == BSR_i ? BSR2_u : RET2_u);
         end
      end else begin
         a.ill = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_has[k]   = 1'b0;
         m_cur[k]   = '{u: NOP_u, last: 1'b0, ill: 1'b0};
         m_nxt[k]   = m_cur[k];
      end
   endtask

   task automatic model_tick(input int k);
      bit    rdy;
      item_t a, b;
      int    n;
      rdy = !flush && (!m_valid[k] || (uinst_ready && m_cur[k].last));
      if (flush) begin
         m_valid[k] = 1'b0;
         m_has[k]   = 1'b0;
      end else if (inst_valid && rdy) begin
         expand(inst, k == 1, a, b, n);
         m_cur[k]   = a;
         m_nxt[k]   = b;
         m_has[k]   = (n > 1);
         m_valid[k] = 1'b1;
      end else if (m_valid[k] && uinst_ready) begin
         if (m_has[k]) begin
            m_cur[k] = m_nxt[k];
            m_has[k] = 1'b0;
         end else begin
            m_valid[k] = 1'b0;
         end
      end
   endtask

   function automatic logic [36:0] expv(input int k);
      return {m_valid[k], m_cur[k].last, m_cur[k].ill, m_cur[k].u};
   endfunction

   function automatic bit exp_rdy();
      return !flush && (!m_valid[1] || (uinst_ready && m_cur[1].last));
   endfunction

   task automatic drive(input bit iv, input logic [19:0] ins,
                        input bit ur, input bit fl);
      @(negedge clk);
      inst_valid  = iv;
      inst        = ins;
      uinst_ready = ur;
      flush       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick(0);
      model_tick(1);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (o1 !== expv(1)) begin
         errors++;
         $display("FAIL reset_out: got %h want %h", o1, expv(1));
      end
      checks++;
      if (rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", rdy1);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (o0 !== {3'b000, NOP_u}) begin
         errors++;
         $display("FAIL reset_out0: got %h want %h", o0, {3'b000, NOP_u});
      end
   endtask

   task automatic test_movwk();
      logic [36:0] want;
      want = {3'b110, fix(MOVwK_u)};
      drive(1, {MOVwK_i, 16'h1234}, 1, 0);
      checks++;
      if (rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL mov_ready: got %b want 1", rdy1);
      end
      tick();
      checks++;
      if (o1 !== want || o1 !== expv(1)) begin
         errors++;
         $display("FAIL mov_out: got %h want %h", o1, want);
      end
      drive(0, '0, 1, 0);
      checks++;
      if (rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL mov_ready2: got %b want 1", rdy1);
      end
      tick();
      checks++;
      if (o1 !== expv(1)) begin
         errors++;
         $display("FAIL mov_retire: got %h want %h", o1, expv(1));
      end
   endtask

   task automatic test_back_to_back();
      drive(1, {BSR_i, 16'h0042}, 1, 0);
      tick();
      checks++;
      if (o1 !== {3'b100, fix(BSR_u)}) begin
         errors++;
         $display("FAIL b2b_bsr: got %h want %h", o1, {3'b100, fix(BSR_u)});
      end
      drive(1, {ADDwK_i, 16'h0007}, 1, 0);
      checks++;
      if (rdy1 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ready0: got %b want 0", rdy1);
      end
      tick();
      checks++;
      if (o1 !== {3'b110, fix(BSR2_u)}) begin
         errors++;
         $display("FAIL b2b_bsr2: got %h want %h", o1, {3'b110, fix(BSR2_u)});
      end
      checks++;
      if (rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready1: got %b want 1", rdy1);
      end
      tick();
      checks++;
      if (o1 !== {3'b110, fix(ADDwK_u)} || o1 !== expv(1)) begin
         errors++;
         $display("FAIL b2b_add: got %h want %h", o1, {3'b110, fix(ADDwK_u)});
      end
      drive(0, '0, 1, 0);
      tick();
   endtask

   task automatic test_stall();
      drive(1, {RET_i, 16'h0000}, 1, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, '0, 0, 0);
         checks++;
         if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready%0d: got %b want 0", i, rdy1);
         end
         tick();
         checks++;
         if (o1 !== {3'b100, fix(RET_u)}) begin
            errors++;
            $display("FAIL stall_hold%0d: got %h want %h", i, o1, {3'b100, fix(RET_u)});
         end
      end
      drive(0, '0, 1, 0);
      tick();
      checks++;
      if (o1 !== {3'b110, fix(RET2_u)}) begin
         errors++;
         $display("FAIL stall_ret2: got %h want %h", o1, {3'b110, fix(RET2_u)});
      end
      tick();
      checks++;
      if (val1 !== 1'b0 || o1 !== expv(1)) begin
         errors++;
         $display("FAIL stall_done: got %h want %h", o1, expv(1));
      end
   endtask

   task automatic test_flush();
      drive(1, {BSR_i, 16'h0011}, 1, 0);
      tick();
      drive(1, {MOVwK_i, 16'h0099}, 1, 1);
      checks++;
      if (rdy1 !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready: got %b want 0", rdy1);
      end
      tick();
      checks++;
      if (val1 !== 1'b0 || o1 !== expv(1)) begin
         errors++;
         $display("FAIL flush_out: got %h want %h", o1, expv(1));
      end
      drive(1, {MOVwK_i, 16'h0099}, 1, 0);
      tick();
      checks++;
      if (o1 !== {3'b110, fix(MOVwK_u)}) begin
         errors++;
         $display("FAIL flush_replay: got %h want %h", o1, {3'b110, fix(MOVwK_u)});
      end
      drive(0, '0, 1, 0);
      tick();
   endtask

   task automatic test_ext();
      drive(1, 20'h0F000, 1, 0);
      tick();
      checks++;
      if (o1 !== {3'b111, NOP_u}) begin
         errors++;
         $display("FAIL ext_illegal: got %h want %h", o1, {3'b111, NOP_u});
      end
      checks++;
      if (o0 !== {3'b110, NOP_u}) begin
         errors++;
         $display("FAIL ext_off_nop: got %h want %h", o0, {3'b110, NOP_u});
      end
      drive(1, {4'h0, X_ADDww_i, 12'h345}, 1, 0);
      tick();
      checks++;
      if (o1 !== {3'b110, ADDww_u} || o0 !== expv(0)) begin
         errors++;
         $display("FAIL ext_addww: got %h/%h want %h/%h", o1, o0, {3'b110, ADDww_u}, expv(0));
      end
      drive(0, '0, 1, 0);
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1, {BSR_i, 16'h0ABC}, 1, 0);
      tick();
      checks++;
      if (o1 !== expv(1)) begin
         errors++;
         $display("FAIL rmid_pre: got %h want %h", o1, expv(1));
      end
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (o1 !== expv(1) || o0 !== expv(0) || rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL rmid_async: got %h rdy %b want %h rdy 1", o1, rdy1, expv(1));
      end
      @(negedge clk);
      inst_valid = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic [19:0] ins;
      for (int i = 0; i < 400; i++) begin
         ins = 20'($urandom);
         ins[19:16] = 4'($urandom_range(0, 15));
         drive($urandom_range(0, 3) != 0, ins,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         checks++;
         if (rdy1 !== exp_rdy() || rdy0 !== exp_rdy()) begin
            errors++;
            $display("FAIL rnd_ready%0d: got %b/%b want %b", i, rdy1, rdy0, exp_rdy());
         end
         tick();
         checks++;
         if (o1 !== expv(1)) begin
            errors++;
            $display("FAIL rnd_out1_%0d: got %h want %h", i, o1, expv(1));
         end
         checks++;
         if (o0 !== expv(0)) begin
            errors++;
            $display("FAIL rnd_out0_%0d: got %h want %h", i, o0, expv(0));
         end
      end
   endtask

   initial begin
      init_tables();
      test_reset();
      test_movwk();
      test_back_to_back();
      test_stall();
      test_flush();
      test_ext();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mir_seq.md
# mir_seq

Parametrised microinstruction sequencer stage for the EV22 multi-stage processor; successor to the single-cycle combinational first-nibble microinstruction decoder. It accepts fetched instructions over a valid/ready handshake and emits one or more registered microinstructions per instruction. It decodes both first-nibble opcodes and, when enabled, second-nibble extended opcodes (first nibble 0). It sits between the instruction register and the execute stage and supports stall and flush.

## Interface
- INST_W, 20, instruction width; opcode is INST_W-1:INST_W-4.
- UINST_W, 34, microinstruction width; field positions come from the shared microinstruction field indices.
- MAX_STEPS, 2, maximum microinstructions per instruction (≥1); sets step counter width to clog2(MAX_STEPS), minimum 1.
- EXT_DECODE, 1, 1 = decode INST_W-5:INST_W-8 when the first nibble is 0; 0 = first nibble 0 is NOP.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  stage can accept an instruction this cycle.
- inst  in  INST_W  instruction word.
- flush  in  1  synchronous; discard the current and output-held instruction.
- uinst_valid  out  1  uinst holds a valid microinstruction.
- uinst_ready  in  1  downstream accepts uinst this cycle (low = stall).
- uinst  out  UINST_W  registered microinstruction.
- uinst_last  out  1  uinst is the final step of its instruction.
- uinst_illegal  out  1  opcode is not in the table; uinst is NOP_u.

## Operation
- Reset values: uinst_valid=0, uinst=NOP_u, uinst_last=0, uinst_illegal=0, step=0, held instruction=0. inst_ready follows its equation below, so it is 1 after reset.
- inst_ready = !uinst_valid || (uinst_ready && uinst_last). This is a combinational path from uinst_ready; it is forced to 0 while flush=1.
- Accept = inst_valid && inst_ready. On accept:
  - latch inst into the held register;
  - set step=0;
  - load uinst with step 0 of the decode;
  - set uinst_valid=1.
- Advance = uinst_valid && uinst_ready && !uinst_last. On advance: step+1, and uinst is loaded with the next step of the held instruction.
- Retire = uinst_valid && uinst_ready && uinst_last. On retire with no accept: uinst_valid=0, and uinst/uinst_last/uinst_illegal hold their values.
- If uinst_valid && !uinst_ready (stall), all outputs and state hold.
- Decode:
  - the rom returns the full microinstruction, a last flag and an illegal flag for (opcode, step);
  - for first-nibble opcodes, the busA and shifter fields are overridden with the fixed FIX_A_SH constant;
  - extended opcodes supply all fields.
- Step table (package):
  - BSR and RET take 2 steps (BSR_u then BSR2_u; RET_u then RET2_u);
  - all other opcodes take 1 step;
  - with MAX_STEPS=1, step 1 is never issued and step 0 is flagged last.
- Unknown opcode: a single step of NOP_u with uinst_illegal=1.
- Opcode 0 with EXT_DECODE=0: NOP_u, last=1, illegal=0.

## Timing
- Latency is 1 cycle: accept at edge N gives uinst_valid with step 0 after edge N.
- Back-to-back: retire and accept on the same edge gives the new step 0 with no bubble. Sustained throughput is 1 microinstruction per cycle.
- flush has priority over everything: at the next edge uinst_valid=0, step=0, and any concurrent inst_valid is not accepted.
- Reset asserted mid-sequence immediately forces the reset values, independent of clk.
- The step counter never exceeds MAX_STEPS-1. A table entry requesting more steps is truncated, with the last step forced to last=1.

## Structure
- Package mir_pkg holds:
  - microinstruction field indices (iALUC_*, iKMX, iM_*, iBUSA_*, iBUSB_*, iBUSC_*, iSH_*, iT_*);
  - opcode constants (*_i);
  - microinstruction constants (*_u, including BSR2_u, RET2_u, NOP_u, FIX_A_SH);
  - the per-opcode step-count table;
  - the state enum (EMPTY, ISSUE).
- Sub-module mir_rom: purely combinational, maps (inst, step) → {uinst, last, illegal}. mir_seq holds the FSM, the step counter and the output registers.

## Test plan
- Reset, then inst=MOVwK_i with uinst_ready=1 → one cycle later uinst=MOVwK_u with the FIX_A_SH fields, uinst_last=1, uinst_valid=1; inst_ready=1 throughout.
- BSR_i, then ADDwK_i presented the next cycle → uinst sequence BSR_u (last=0), BSR2_u (last=1), ADDwK_u. inst_ready=0 during the BSR_u cycle. No bubble.
- RET_i with uinst_ready=0 for 3 cycles → RET_u held stable with inst_ready=0; after release, RET2_u follows, then uinst_valid=0.
- flush=1 while BSR2 is pending and inst_valid=1 → next cycle uinst_valid=0 and the new instruction is not accepted. Re-presenting it is accepted normally.
- inst=20'h0F000 with EXT_DECODE=1 and 0xF unused → NOP_u with uinst_illegal=1. Same input with EXT_DECODE=0 → NOP_u with illegal=0.
- Assert reset_n low mid-BSR, between clock edges → outputs immediately return to reset values.
